// File: rtl/ebpf_pkg.sv
// Shared definitions for the eBPF core front end: instruction field layout,
// special opcodes, fetch FSM states and the decoded-instruction record.
package ebpf_pkg;

  localparam int unsigned IMEM_AW = 12;

  localparam int unsigned OPC_HI = 63;
  localparam int unsigned OPC_LO = 56;
  localparam int unsigned SRC_HI = 55;
  localparam int unsigned SRC_LO = 52;
  localparam int unsigned DST_HI = 51;
  localparam int unsigned DST_LO = 48;
  localparam int unsigned OFF_HI = 47;
  localparam int unsigned OFF_LO = 32;
  localparam int unsigned IMM_HI = 31;
  localparam int unsigned IMM_LO = 0;

  localparam logic [7:0] LDDW_OPC_DEF = 8'h18;
  localparam logic [7:0] EXIT_OPC_DEF = 8'h95;

  typedef enum logic [1:0] {StIdle, StRun, StWide, StDrain} fetch_state_e;

  typedef struct packed {
    logic [7:0]         opcode;
    logic [3:0]         src;
    logic [3:0]         dst;
    logic [15:0]        offset;
    logic [63:0]        imm64;
    logic               wide;
    logic [IMEM_AW-1:0] pc;
  } instr_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ebpf_instr_split.sv
// Splits one 64-bit instruction word into its fields; imm is sign-extended,
// pc and wide are left zero for the fetch stage to fill in.
module ebpf_instr_split
  import ebpf_pkg::*;
(
  input  logic [63:0] word_i,
  output instr_t      instr_o
);

  always_comb begin
    instr_o        = '0;
    instr_o.opcode = word_i[OPC_HI:OPC_LO];
    instr_o.src    = word_i[SRC_HI:SRC_LO];
    instr_o.dst    = word_i[DST_HI:DST_LO];
    instr_o.offset = word_i[OFF_HI:OFF_LO];
    instr_o.imm64  = sext32(word_i[IMM_HI:IMM_LO]);
  end

endmodule

// File: rtl/ebpf_fetch.sv
// eBPF instruction fetch: walks the PC through an async-read word memory,
// fuses two-word LD_IMM64 and hands instructions to decode over valid/ready.
module ebpf_fetch
  import ebpf_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_AW,
  parameter logic [7:0]  LDDW_OPC = LDDW_OPC_DEF,
  parameter logic [7:0]  EXIT_OPC = EXIT_OPC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [7:0]        out_opcode,
  output logic [3:0]        out_src,
  output logic [3:0]        out_dst,
  output logic [15:0]       out_offset,
  output logic [63:0]       out_imm,
  output logic              out_wide,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] LastPc = '1;
  localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       hold_q, hold_d;
  instr_t            first_q, first_d;
  instr_t            out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              fault_q, fault_d;

  instr_t word_instr;
  instr_t cur;
  logic   slot_free;

  ebpf_instr_split u_split (
    .word_i  (imem_rdata),
    .instr_o (word_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    first_d     = first_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    fault_d     = fault_q;

    slot_free = !out_valid_q || out_ready;
    cur       = word_instr;
    cur.pc    = pc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q != StIdle && redirect_valid) begin
      // Redirect beats everything, including a same-cycle handshake.
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      hold_d      = '0;
      state_d     = StRun;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc_d    = start_pc;
            fault_d = 1'b0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (slot_free) begin
            if (cur.opcode == EXIT_OPC) begin
              out_d       = cur;
              out_valid_d = 1'b1;
              state_d     = StDrain;
            end else if (cur.opcode == LDDW_OPC) begin
              if (pc_q == LastPc) begin
                fault_d = 1'b1;
                state_d = StIdle;
              end else begin
                hold_d  = imem_rdata[IMM_HI:IMM_LO];
                first_d = cur;
                pc_d    = pc_q + PcOne;
                state_d = StWide;
              end
            end else begin
              out_d       = cur;
              out_valid_d = 1'b1;
              if (pc_q == LastPc) begin
                fault_d = 1'b1;
                state_d = StIdle;
              end else begin
                pc_d = pc_q + PcOne;
              end
            end
          end
        end
        StWide: begin
          if (slot_free) begin
            out_d       = first_q;
            out_d.imm64 = {imem_rdata[IMM_HI:IMM_LO], hold_q};
            out_d.wide  = 1'b1;
            out_valid_d = 1'b1;
            if (pc_q == LastPc) begin
              fault_d = 1'b1;
              state_d = StIdle;
            end else begin
              pc_d    = pc_q + PcOne;
              state_d = StRun;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      hold_q      <= '0;
      first_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_q.pc;
  assign out_opcode = out_q.opcode;
  assign out_src    = out_q.src;
  assign out_dst    = out_q.dst;
  assign out_offset = out_q.offset;
  assign out_imm    = out_q.imm64;
  assign out_wide   = out_q.wide;
  assign busy       = (state_q != StIdle);
  assign fault      = fault_q;
  assign done       = (state_q == StDrain) && out_valid_q && out_ready && !redirect_valid;

endmodule

// File: doc/ebpf_fetch.md
Name: ebpf_fetch

Overview:
Instruction fetch stage for the eBPF core, directly upstream of decode and directly downstream of the instruction memory. The memory is asynchronous-read with word addressing and 64-bit words.
- Drives the memory address from an internal PC and splits each word into fields: opcode[63:56], src[55:52], dst[51:48], offset[47:32], imm[31:0].
- Fuses two-word LD_IMM64 into a single output with a 64-bit immediate.
- Presents instructions to decode over a valid/ready handshake; handles branch redirects and program end.

Parameters:
ADDR_W, 12, word-address width; must match the instruction memory address_size.
LDDW_OPC, 8'h18, opcode of the two-word 64-bit immediate load.
EXIT_OPC, 8'h95, opcode that ends the program.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin fetching at start_pc
start_pc  in  ADDR_W  first instruction word address
imem_addr  out  ADDR_W  instruction memory address (combinational from pc)
imem_rdata  in  64  instruction memory data, valid in the same cycle as the address
out_valid  out  1  output instruction valid
out_ready  in  1  decode accepts the output
out_pc  out  ADDR_W  word address of the first word of the instruction
out_opcode  out  8  opcode field
out_src  out  4  src register field
out_dst  out  4  dst register field
out_offset  out  16  offset field
out_imm  out  64  immediate: imm32 sign-extended, or fused 64-bit immediate
out_wide  out  1  instruction is a fused LD_IMM64
redirect_valid  in  1  branch taken; flush and refetch
redirect_pc  in  ADDR_W  redirect target word address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the EXIT instruction is accepted
fault  out  1  sticky; PC ran past the last word; cleared by start or rst

Behaviour:
- Reset values: state IDLE; pc, hold, all out_* fields and out_wide 0; out_valid 0; busy 0; done 0; fault 0.
- imem_addr = pc at all times.
- Slot free: slot_free = !out_valid || out_ready. While out_valid && !out_ready, every out_* field holds stable.
- out_valid is cleared on handshake when nothing new is loaded.
- IDLE:
  - start → pc <= start_pc, fault <= 0, state RUN.
  - redirect_valid is ignored.
- RUN, when slot_free:
  - Opcode EXIT_OPC: load outputs; state DRAIN.
  - Opcode LDDW_OPC: hold <= imem_rdata[31:0]; pc <= pc+1; state WIDE; nothing is loaded and out_valid clears if it was handshaken.
  - Any other opcode: load outputs with out_imm = sign-extended imm32 and out_wide = 0; pc <= pc+1.
- RUN, when the slot is not free: no state change.
- WIDE, when slot_free:
  - Load outputs with fields from the first word (captured alongside hold).
  - out_imm = {imem_rdata[31:0], hold}; out_wide = 1; out_pc = pc-1.
  - pc <= pc+1; state RUN.
  - Fields of the second word other than imm are ignored.
- DRAIN: on the out_valid && out_ready handshake, done pulses for 1 cycle and state goes to IDLE.
- End of memory:
  - A non-EXIT instruction at pc = 2^ADDR_W-1 is issued normally; then fault <= 1 and state goes to IDLE (no wrap to 0).
  - LDDW_OPC at the last address is not issued: fault <= 1, state IDLE.
- Redirect (RUN/WIDE/DRAIN): highest priority.
  - pc <= redirect_pc; out_valid <= 0, even if a handshake occurs in the same cycle; state RUN; hold is discarded.
- start while busy is ignored.
- A start coincident with redirect in IDLE obeys start.
- Latency: start at cycle 0 → memory read in cycle 1 → out_valid in cycle 2. Throughput is 1 instruction/cycle, and 1 per 2 cycles for LD_IMM64.
- rst mid-operation returns all state to reset values immediately (asynchronous).

Decomposition:
- Shared package ebpf_pkg: field bit positions (OPC_HI/LO, SRC, DST, OFF, IMM), the LDDW/EXIT opcode constants, and a packed instr_t struct {opcode, src, dst, offset, imm64, wide, pc}.
- One combinational sub-module, ebpf_instr_split: 64-bit word → instr_t fields. The FSM, pc and output register stay in ebpf_fetch.

Test Plan:
- Linear program: mem[0..2] = ALU, ALU, EXIT(95..), start_pc=0, out_ready=1 → out_pc 0,1,2 on consecutive cycles starting cycle 2; done pulses when pc 2 is accepted; busy drops the next cycle.
- LD_IMM64 fusion: mem[4]=18_1_0_0000_89ABCDEF, mem[5]=00_0_0_0000_01234567 → one output with out_pc=4, out_wide=1, out_imm=64'h0123456789ABCDEF, out_dst=0, out_src=1; the next output has out_pc=6.
- Sign extension: imm32 = 32'h80000000 → out_imm = 64'hFFFFFFFF80000000.
- Backpressure: out_ready=0 for 3 cycles mid-stream → outputs held stable, pc unchanged; on release, no instruction is lost or duplicated.
- Redirect: redirect_valid with redirect_pc=10 in the cycle out_pc=3 is handshaken → out_valid drops next cycle, next issued out_pc=10; also issued while in WIDE → hold is discarded.
- End of memory: start_pc=4095 with a non-EXIT word → issued, then fault=1 and busy=0; LD_IMM64 at 4095 → nothing issued, fault=1; rst asserted mid-run → all outputs 0 asynchronously.
